// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction memory loader: state codes, length field width, word sizing.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
package imem_loader_pkg;

  // Width of the little-endian word-count field that opens every frame
  localparam int LEN_W = 16;

  // Loader FSM encodings (kept as plain vectors for legacy tooling)
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_LO = 3'd1;
  localparam logic [2:0] ST_LEN_HI = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_CHECK  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_ERR    = 3'd6;

  // Number of stream bytes that make up one instruction word
  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a little-endian byte stream into DATA_W-bit words (first byte lands in bits [7:0]).
// Latency: word_vld/word_dat are combinational with the last byte of each word.
// Backpressure: none; accepts a byte on every cycle byte_vld is high.
module byte_packer
  import imem_loader_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              byte_vld,
  input  logic [7:0]        byte_dat,
  output logic              word_vld,
  output logic [DATA_W-1:0] word_dat
);

  localparam int BYTES = bytes_per_word(DATA_W);
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [CNT_W-1:0]  byte_cnt;
  logic [DATA_W-1:0] word_buf;

  assign word_vld = byte_vld && (byte_cnt == CNT_W'(BYTES - 1));

  // Completed word: earlier bytes from the buffer, the final byte straight from the stream
  always_comb begin
    word_dat = word_buf;
    word_dat[DATA_W-1 -: 8] = byte_dat;
  end

  // Insert each byte at its lane and advance the byte position, wrapping after the last lane
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      byte_cnt <= '0;
      word_buf <= '0;
    end else if (byte_vld) begin
      word_buf[{byte_cnt, 3'b000} +: 8] <= byte_dat;
      byte_cnt <= word_vld ? '0 : byte_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory; holds core in reset until valid.
// Latency: mem_we pulses 1 cycle after the last byte of each word; done/error 1 cycle after the checksum byte.
// Backpressure: never stalls while loading (one byte per cycle); in_ready low in IDLE/DONE/ERR.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              error
);

  localparam int MAX_WORDS = 2 ** ADDR_W;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [7:0]        len_lo;
  logic [LEN_W-1:0]  len_words;
  logic [LEN_W-1:0]  len_in;
  logic [ADDR_W:0]   word_cnt;
  logic [7:0]        xor_acc;
  logic              accept;
  logic              start_ok;
  logic              last_word;
  logic              word_vld;
  logic [DATA_W-1:0] word_dat;

  assign in_ready  = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                     (state == ST_DATA)   || (state == ST_CHECK);
  assign accept    = in_valid && in_ready;
  assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
  assign len_in    = {in_data, len_lo};
  // word_cnt is one bit wider than the address so a full 2**ADDR_W load compares correctly
  assign last_word = (LEN_W'(word_cnt) + LEN_W'(1)) == len_words;

  byte_packer #(
    .DATA_W (DATA_W)
  ) u_packer (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_ok),
    .byte_vld (accept && (state == ST_DATA)),
    .byte_dat (in_data),
    .word_vld (word_vld),
    .word_dat (word_dat)
  );

  // Next-state decode for the frame parser
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_ok) state_nxt = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (accept) state_nxt = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (accept) begin
          if (32'(len_in) > MAX_WORDS) state_nxt = ST_ERR;
          else if (len_in == '0)       state_nxt = ST_CHECK;
          else                         state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (word_vld && last_word) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (accept) state_nxt = (in_data == xor_acc) ? ST_DONE : ST_ERR;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register plus status flags registered from the next state so they track it on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      core_rst <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= state_nxt;
      core_rst <= (state_nxt != ST_DONE);
      done     <= (state_nxt == ST_DONE);
      error    <= (state_nxt == ST_ERR);
    end
  end

  // Length capture, word counter and running checksum of data bytes
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      len_lo    <= '0;
      len_words <= '0;
      word_cnt  <= '0;
      xor_acc   <= '0;
    end else begin
      if (accept && (state == ST_LEN_LO)) len_lo <= in_data;
      if (accept && (state == ST_LEN_HI)) len_words <= len_in;
      if (accept && (state == ST_DATA))   xor_acc <= xor_acc ^ in_data;
      if (word_vld)                       word_cnt <= word_cnt + (ADDR_W+1)'(1);
    end
  end

  // Memory write port: one-cycle write strobe with address and word held until the next write
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= word_vld;
      if (word_vld) begin
        mem_addr  <= word_cnt[ADDR_W-1:0];
        mem_wdata <= word_dat;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        core_rst;
  logic        done;
  logic        error;

  imem_loader #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_rst  (core_rst),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_writes = 0;
  int frame_cycles = 0;
  logic [7:0]  last_addr;
  logic [39:0] exp_q[$];
  logic [31:0] frame[$];

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected {addr,data}
  always @(negedge clk) begin
    logic [39:0] e;
    if (rst === 1'b0 && mem_we === 1'b1) begin
      n_writes++;
      last_addr = mem_addr;
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e[39:32]));
        check("wr_data", mem_wdata, e[31:0]);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present a byte and hold it until accepted; leaves in_valid high for back-to-back streaming
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  // Start, header, words from 'frame', checksum (xor ^ flip); start raised during word start_at
  task automatic load_frame(input int len, input logic [7:0] flip, input int start_at);
    logic [7:0] x;
    int c0;
    x = 8'h00;
    pulse_start();
    c0 = cyc;
    send_byte(len[7:0]);
    send_byte(len[15:8]);
    for (int w = 0; w < frame.size(); w++) begin
      for (int k = 0; k < 4; k++) begin
        logic [7:0] b;
        b = frame[w][8*k +: 8];
        if (w == start_at && k == 0) start = 1'b1;
        send_byte(b);
        start = 1'b0;
        x = x ^ b;
      end
      exp_q.push_back({w[7:0], frame[w]});
      check("we_latency", 32'(mem_we), 32'd1);
    end
    send_byte(x ^ flip);
    in_valid = 1'b0;
    frame_cycles = cyc - c0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    logic [7:0] part[6];
    rst = 1'b1; start = 1'b0; in_valid = 1'b1; in_data = 8'h55;

    // 1: reset state, bytes ignored
    repeat (2) @(posedge clk);
    #1;
    check("rst_core_rst", 32'(core_rst), 32'd1);
    check("rst_mem_we",   32'(mem_we),   32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_error",    32'(error),    32'd0);
    check("rst_addr",     32'(mem_addr), 32'd0);
    check("rst_wdata",    mem_wdata,     32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd0);
    check("idle_core_rst", 32'(core_rst), 32'd1);
    in_valid = 1'b0;

    // 2: good two-word frame
    frame = '{32'h00A00013, 32'h04030201};
    load_frame(2, 8'h00, -1);
    check("t2_done",     32'(done),     32'd1);
    check("t2_error",    32'(error),    32'd0);
    check("t2_core_rst", 32'(core_rst), 32'd0);
    check("t2_in_ready", 32'(in_ready), 32'd0);

    // 3: same frame, bad checksum
    load_frame(2, 8'h01, -1);
    check("t3_error",    32'(error),    32'd1);
    check("t3_done",     32'(done),     32'd0);
    check("t3_core_rst", 32'(core_rst), 32'd1);

    // 4: oversize length, then empty frame
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h01);
    in_valid = 1'b0;
    check("t4_len_err",   32'(error),    32'd1);
    check("t4_in_ready",  32'(in_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    frame = {};
    load_frame(0, 8'h00, -1);
    check("t4_empty_done", 32'(done),     32'd1);
    check("t4_empty_crst", 32'(core_rst), 32'd0);

    // 5: full 256-word frame streamed back-to-back, start pulsed mid-data
    frame = {};
    for (int i = 0; i < 256; i++) frame.push_back($urandom);
    w0 = n_writes;
    load_frame(256, 8'h00, 100);
    @(negedge clk);
    #1;
    check("t5_writes",    32'(n_writes - w0), 32'd256);
    check("t5_last_addr", 32'(last_addr),     32'h0000_00FF);
    check("t5_cycles",    32'(frame_cycles),  32'd1027);
    check("t5_done",      32'(done),          32'd1);
    @(posedge clk); #1;

    // 6: reset after 6 data bytes, then a clean reload
    part = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77};
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h00);
    for (int i = 0; i < 6; i++) begin
      send_byte(part[i]);
      if (i == 3) exp_q.push_back({8'h00, 32'h11223344});
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6_in_ready", 32'(in_ready), 32'd0);
    check("t6_mem_we",   32'(mem_we),   32'd0);
    check("t6_core_rst", 32'(core_rst), 32'd1);
    check("t6_done",     32'(done),     32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    frame = '{32'hDEADBEEF, 32'h0BADF00D};
    load_frame(2, 8'h00, -1);
    check("t6_done_after", 32'(done), 32'd1);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
